// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states, idle select code.
// is_multicycle() marks the ops that hold the ALU for more than one cycle.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_SUB  = 4'd0,
        OP_ADD  = 4'd1,
        OP_MUL  = 4'd2,
        OP_MOV  = 4'd3,
        OP_COMP = 4'd4,
        OP_DIV  = 4'd5,
        OP_XOR  = 4'd6,
        OP_AND  = 4'd7,
        OP_NOT  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] SEL_IDLE = 4'hF;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_SHR;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request, ALU-mux and response signals of the ALU sequencer.
// slave = sequencer side, master = requester/ALU/consumer side.
interface alu_seq_ctrl_if #(
    parameter int N = 4
);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [3:0]   alu_select;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        output req_ready, alu_select, alu_a, alu_b, rsp_valid, rsp_result, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        input  req_ready, alu_select, alu_a, alu_b, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_seq_lat_cnt.sv
// 4-bit latency down-counter: load wins over decrement, zero flag is combinational.
// Latency: value visible the cycle after load/decrement; no backpressure.
module alu_seq_lat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);
endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one op at a time through an external ALU mux; ALU_SEQ_DIV0_CHK_EN short-circuits DIV by zero.
// Latency: 2 cycles single-cycle ops, LAT+1 for MUL/DIV, 1 for illegal/short-circuited ops.
// Backpressure: req_ready only in IDLE; response held in DONE until rsp_ready.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int N       = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_ctrl_if.slave  bus
);
`ifdef ALU_SEQ_DIV0_CHK_EN
    localparam bit DIV0_CHK = 1'b1;
`else
    localparam bit DIV0_CHK = 1'b0;
`endif

    localparam logic [3:0] MUL_LD = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_LD = 4'(DIV_LAT - 1);

    state_e     state;
    logic       cnt_zero;
    logic       cnt_load;
    logic       cnt_dec;
    logic       accept;
    logic       div0_short;

    assign accept     = (state == ST_IDLE) && bus.req_valid;
    assign div0_short = DIV0_CHK && (bus.req_op == OP_DIV) && (bus.req_b == '0);
    assign cnt_load   = accept && is_multicycle(bus.req_op) && !div0_short;
    assign cnt_dec    = (state == ST_WAIT) && !cnt_zero;

    alu_seq_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val ((bus.req_op == OP_MUL) ? MUL_LD : DIV_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b0;
            bus.alu_select <= SEL_IDLE;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        bus.alu_a     <= bus.req_a;
                        bus.alu_b     <= bus.req_b;
                        bus.req_ready <= 1'b0;
                        // Illegal ops and short-circuited DIV never reach the ALU mux.
                        if (!is_legal(bus.req_op) || div0_short) begin
                            state          <= ST_DONE;
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_result <= div0_short ? '1 : '0;
                        end else begin
                            state          <= is_multicycle(bus.req_op) ? ST_WAIT : ST_EXEC;
                            bus.alu_select <= bus.req_op;
                        end
                    end
                end
                ST_EXEC, ST_WAIT: begin
                    if (state == ST_EXEC || cnt_zero) begin
                        state          <= ST_DONE;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_err    <= 1'b0;
                        bus.rsp_result <= bus.alu_result;
                        bus.alu_select <= SEL_IDLE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU mux; default parameters.
module tb_alu_seq_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.N(N)) bus ();

    alu_seq_ctrl #(.N(N), .MUL_LAT(2), .DIV_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU result mux driven by the sequencer's select/operands.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_select)
            4'd0:  bus.alu_result = bus.alu_a - bus.alu_b;
            4'd1:  bus.alu_result = bus.alu_a + bus.alu_b;
            4'd2:  bus.alu_result = bus.alu_a * bus.alu_b;
            4'd3:  bus.alu_result = bus.alu_a;
            4'd4:  bus.alu_result = (bus.alu_a < bus.alu_b) ? 4'd1 : 4'd0;
            4'd5:  bus.alu_result = (bus.alu_b == '0) ? '1 : bus.alu_a / bus.alu_b;
            4'd6:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'd7:  bus.alu_result = bus.alu_a & bus.alu_b;
            4'd8:  bus.alu_result = ~bus.alu_a;
            4'd9:  bus.alu_result = bus.alu_a << 1;
            4'd10: bus.alu_result = bus.alu_a >> 1;
            default: bus.alu_result = '0;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       err;
        int         lat;
        logic [3:0] sel;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [0:NV-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request; returns after the acceptance edge (+#1, i.e. cycle 1).
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'($urandom_range(0, 15));
        bus.req_a     = 4'($urandom_range(0, 15));
        bus.req_b     = 4'($urandom_range(0, 15));
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        v = vecs[idx];
        issue(v.op, v.a, v.b);
        lat = 1;
        check($sformatf("v%0d sel", idx), bus.alu_select, v.sel);
        while (!bus.rsp_valid && lat < 20) begin
            check($sformatf("v%0d busy_ready", idx), bus.req_ready, 1'b0);
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d lat", idx), lat, v.lat);
        check($sformatf("v%0d result", idx), bus.rsp_result, v.res);
        check($sformatf("v%0d err", idx), bus.rsp_err, v.err);
        check($sformatf("v%0d done_sel", idx), bus.alu_select, 4'hF);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check($sformatf("v%0d ready_after", idx), bus.req_ready, 1'b1);
        check($sformatf("v%0d valid_after", idx), bus.rsp_valid, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " req_ready"}, bus.req_ready, 1'b1);
        check({tag, " rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, " rsp_result"}, bus.rsp_result, 4'd0);
        check({tag, " rsp_err"}, bus.rsp_err, 1'b0);
        check({tag, " alu_select"}, bus.alu_select, 4'hF);
        check({tag, " alu_a"}, bus.alu_a, 4'd0);
        check({tag, " alu_b"}, bus.alu_b, 4'd0);
    endtask

    initial begin
        logic [3:0] held_res;
        logic       held_err;
        int         lat;

        //            op     a      b      res    err   lat sel
        vecs[0]  = '{4'd1,  4'd3,  4'd4,  4'd7,  1'b0, 2, 4'd1};
        vecs[1]  = '{4'd0,  4'd2,  4'd5,  4'd13, 1'b0, 2, 4'd0};
        vecs[2]  = '{4'd2,  4'd3,  4'd5,  4'd15, 1'b0, 3, 4'd2};
        vecs[3]  = '{4'd2,  4'd7,  4'd3,  4'd5,  1'b0, 3, 4'd2};
        vecs[4]  = '{4'd3,  4'd9,  4'd1,  4'd9,  1'b0, 2, 4'd3};
        vecs[5]  = '{4'd4,  4'd3,  4'd9,  4'd1,  1'b0, 2, 4'd4};
        vecs[6]  = '{4'd5,  4'd13, 4'd4,  4'd3,  1'b0, 5, 4'd5};
`ifdef ALU_SEQ_DIV0_CHK_EN
        vecs[7]  = '{4'd5,  4'd9,  4'd0,  4'd15, 1'b1, 1, 4'hF};
`else
        vecs[7]  = '{4'd5,  4'd9,  4'd0,  4'd15, 1'b0, 5, 4'd5};
`endif
        vecs[8]  = '{4'd6,  4'd12, 4'd10, 4'd6,  1'b0, 2, 4'd6};
        vecs[9]  = '{4'd7,  4'd12, 4'd10, 4'd8,  1'b0, 2, 4'd7};
        vecs[10] = '{4'd8,  4'd5,  4'd0,  4'd10, 1'b0, 2, 4'd8};
        vecs[11] = '{4'd9,  4'd9,  4'd0,  4'd2,  1'b0, 2, 4'd9};
        vecs[12] = '{4'd10, 4'd9,  4'd0,  4'd4,  1'b0, 2, 4'd10};
        vecs[13] = '{4'd12, 4'd7,  4'd7,  4'd0,  1'b1, 1, 4'hF};
        vecs[14] = '{4'd15, 4'd1,  4'd2,  4'd0,  1'b1, 1, 4'hF};

        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_a     = 4'd0;
        bus.req_b     = 4'd0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset req_ready", bus.req_ready, 1'b1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // SUB response held under consumer backpressure.
        issue(4'd0, 4'd7, 4'd2);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold first_valid", bus.rsp_valid, 1'b1);
        held_res = bus.rsp_result;
        held_err = bus.rsp_err;
        check("hold result", held_res, 4'd5);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold valid", bus.rsp_valid, 1'b1);
            check("hold result_stable", bus.rsp_result, held_res);
            check("hold err_stable", bus.rsp_err, held_err);
            check("hold req_ready", bus.req_ready, 1'b0);
            check("hold alu_a", bus.alu_a, 4'd7);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("hold ready_after", bus.req_ready, 1'b1);
        check("hold valid_after", bus.rsp_valid, 1'b0);

        // Reset in the middle of a DIV wait discards the op.
        issue(4'd5, 4'd13, 4'd4);
        @(posedge clk);
        #1;
        check("div_rst in_wait_sel", bus.alu_select, 4'd5);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("div_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("div_rst no_rsp", bus.rsp_valid, 1'b0);
            check("div_rst idle_sel", bus.alu_select, 4'hF);
        end

        // Back-to-back traffic still works after the mid-op reset.
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter N, default 4, is the operand and result width in bits.
REQ-002 Parameter MUL_LAT, default 2, is the number of ALU cycles a MUL needs; legal range is 1..15.
REQ-003 Parameter DIV_LAT, default 4, is the number of ALU cycles a DIV needs; legal range is 1..15.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Port req_valid, input, 1 bit: a request is presented.
REQ-007 Port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 Port req_op, input, 4 bits: opcode. 0 SUB, 1 ADD, 2 MUL, 3 MOV, 4 COMP, 5 DIV, 6 XOR, 7 AND, 8 NOT, 9 SHL, 10 SHR; 11..15 are illegal.
REQ-009 Ports req_a and req_b, input, N bits each: operands.
REQ-010 Port alu_select, output, 4 bits: select code to the ALU result mux.
REQ-011 Ports alu_a and alu_b, output, N bits each: latched operands driven to the ALU.
REQ-012 Port alu_result, input, N bits: result returned by the ALU mux.
REQ-013 Port rsp_valid, output, 1 bit: a response is held.
REQ-014 Port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-015 Port rsp_result, output, N bits: the response result.
REQ-016 Port rsp_err, output, 1 bit: the response is an error.

Function
REQ-017 The state machine SHALL have the states IDLE, EXEC, WAIT and DONE.
REQ-018 The block SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1, and op, a and b are latched on acceptance.
REQ-019 On acceptance of a legal single-cycle op (anything but MUL or DIV), the state SHALL go IDLE->EXEC; in EXEC, alu_result is captured at the clock edge and the state goes to DONE.
REQ-020 On acceptance of MUL or DIV, the state SHALL go IDLE->WAIT and load the down-counter with the op's LAT-1.
REQ-021 In WAIT, the counter SHALL decrement each cycle; in the cycle it reads 0, alu_result is captured and the state goes to DONE.
REQ-022 The latency from the acceptance edge to rsp_valid=1 SHALL be 2 cycles for single-cycle ops and LAT+1 cycles for MUL or DIV.
REQ-023 alu_select SHALL equal the latched op in EXEC and WAIT, and SHALL be 4'hF in IDLE and DONE.
REQ-024 alu_a and alu_b SHALL hold the latched operands, stable from acceptance until the block leaves DONE.
REQ-025 In DONE, rsp_valid SHALL be 1 and rsp_result and rsp_err SHALL be held stable until rsp_ready=1; on that handshake the state goes to IDLE.
REQ-026 A new request SHALL NOT be accepted in the same cycle as the response handshake; the minimum issue interval is 3 cycles.
REQ-027 An illegal op (11..15) SHALL go IDLE->DONE directly with rsp_err=1 and rsp_result=0, and alu_select SHALL never show that op.
REQ-028 req_valid deasserted, or request inputs changed, while the block is busy SHALL have no effect.

Reset
REQ-029 When rst_n=0 at a clock edge, the state SHALL become IDLE from any state, including WAIT mid-count or DONE with an unconsumed response, and that operation is discarded.
REQ-030 The reset values SHALL be: req_ready=1 (IDLE), rsp_valid=0, rsp_result=0, rsp_err=0, alu_select=4'hF, alu_a=0, alu_b=0, counter=0.

Configuration
REQ-031 With ALU_SEQ_DIV0_CHK_EN defined, a DIV with req_b==0 SHALL go IDLE->DONE directly with rsp_err=1 and rsp_result all-ones, and no ALU cycles are spent.
REQ-032 Without ALU_SEQ_DIV0_CHK_EN, a DIV with b==0 SHALL run the normal DIV_LAT sequence, return the captured alu_result, and set rsp_err=0.

Structure
REQ-033 Package alu_seq_pkg SHALL hold the opcode enum (values as in REQ-008), the state enum, the constant SEL_IDLE=4'hF, and the function is_multicycle(op).
REQ-034 The down-counter SHALL be the sub-module alu_seq_lat_cnt, 4 bits wide, with load, decrement and a zero flag.

Verification
REQ-035 ADD with a=3, b=4 accepted at cycle 0, alu_result model a+b: rsp_valid=1 at cycle 2 with rsp_result=7 and rsp_err=0; alu_select=1 in cycle 1.
REQ-036 MUL with MUL_LAT=2, a=3, b=5: alu_select=2 for 2 cycles, then rsp_result=15 at cycle 3, and req_ready=0 throughout.
REQ-037 op=12: rsp_valid at cycle 1 with rsp_err=1 and rsp_result=0; alu_select stays 4'hF.
REQ-038 SUB result held with rsp_ready=0 for 5 cycles: rsp_valid, rsp_result and rsp_err are stable; after rsp_ready=1, IDLE and req_ready=1 on the next cycle.
REQ-039 DIV with b=0: with the macro, result 4'hF and rsp_err=1 at cycle 1; without it, DIV_LAT wait cycles and rsp_err=0.
REQ-040 rst_n=0 during WAIT of DIV: the next cycle shows the REQ-030 values, and no response is emitted.
